// File: rtl/izhikevich_state_update.sv
// Izhikevich neuron state-update stage: computes dw with one shared Q-format multiplier, then
// commits v/w and flags spikes. Define IZH_SAT_EN to saturate adds/multiplies instead of wrapping.
module izhikevich_state_update #(
    parameter int unsigned  N      = 32,
    parameter int unsigned  Q      = 16,
    parameter logic [N-1:0] A      = 32'h0000051E,
    parameter logic [N-1:0] B      = 32'h00003333,
    parameter logic [N-1:0] C      = 32'hFFBF0000,
    parameter logic [N-1:0] D      = 32'h00080000,
    parameter logic [N-1:0] V_TH   = 32'h001E0000,
    parameter logic [N-1:0] W_INIT = 32'hFFF30000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dv,
    input  logic [N-1:0] step,
    output logic         out_valid,
    output logic         spike,
    output logic [N-1:0] v_out,
    output logic [N-1:0] w_out
);

    typedef enum logic [2:0] {StIdle, StMulBv, StMulA, StMulStep, StUpdate} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] t_q, t_d;
    logic [N-1:0] dv_q, dv_d;
    logic [N-1:0] step_q, step_d;
    logic [N-1:0] v_q, v_d;
    logic [N-1:0] w_q, w_d;
    logic         out_valid_q, out_valid_d;
    logic         spike_q, spike_d;
    logic [N-1:0] vn, wn;

    // Full-width signed product, floor-shifted by Q, low N bits kept.
    function automatic logic [N-1:0] mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic signed [2*N-1:0] p;
        p = $signed({{N{x[N-1]}}, x}) * $signed({{N{y[N-1]}}, y});
        p = p >>> Q;
`ifdef IZH_SAT_EN
        if (p > $signed({{(N+1){1'b0}}, {(N-1){1'b1}}})) return {1'b0, {(N-1){1'b1}}};
        if (p < $signed({{(N+1){1'b1}}, {(N-1){1'b0}}})) return {1'b1, {(N-1){1'b0}}};
`endif
        return p[N-1:0];
    endfunction

    function automatic logic [N-1:0] sadd(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] s;
        s = x + y;
`ifdef IZH_SAT_EN
        if ((x[N-1] == y[N-1]) && (s[N-1] != x[N-1])) begin
            s = x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    function automatic logic [N-1:0] ssub(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] s;
        s = x - y;
`ifdef IZH_SAT_EN
        if ((x[N-1] != y[N-1]) && (s[N-1] != x[N-1])) begin
            s = x[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    assign in_ready  = (state_q == StIdle) && !clear;
    assign out_valid = out_valid_q;
    assign spike     = spike_q;
    assign v_out     = v_q;
    assign w_out     = w_q;

    // dw in t_q is built from the pre-update v/w, so the commit is forward Euler.
    assign vn = sadd(v_q, dv_q);
    assign wn = sadd(w_q, t_q);

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        dv_d        = dv_q;
        step_d      = step_q;
        v_d         = v_q;
        w_d         = w_q;
        out_valid_d = 1'b0;
        spike_d     = 1'b0;
        if (clear) begin
            state_d = StIdle;
            v_d     = C;
            w_d     = W_INIT;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        dv_d    = dv;
                        step_d  = step;
                        state_d = StMulBv;
                    end
                end
                StMulBv: begin
                    t_d     = mul(B, v_q);
                    state_d = StMulA;
                end
                StMulA: begin
                    t_d     = mul(A, ssub(t_q, w_q));
                    state_d = StMulStep;
                end
                StMulStep: begin
                    t_d     = mul(t_q, step_q);
                    state_d = StUpdate;
                end
                StUpdate: begin
                    if ($signed(vn) >= $signed(V_TH)) begin
                        v_d     = C;
                        w_d     = sadd(wn, D);
                        spike_d = 1'b1;
                    end else begin
                        v_d = vn;
                        w_d = wn;
                    end
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            t_q         <= '0;
            dv_q        <= '0;
            step_q      <= '0;
            v_q         <= C;
            w_q         <= W_INIT;
            out_valid_q <= 1'b0;
            spike_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            dv_q        <= dv_d;
            step_q      <= step_d;
            v_q         <= v_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            spike_q     <= spike_d;
        end
    end

endmodule

// File: tb/tb_izhikevich_state_update.sv
// Scoreboard bench for izhikevich_state_update: directed vectors push expected commits,
// a negedge monitor pops and compares each out_valid pulse, including its cycle.
module tb_izhikevich_state_update;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] dv = '0;
    logic [31:0] step = '0;
    logic        in_ready, out_valid, spike;
    logic [31:0] v_out, w_out;

    localparam logic [31:0] ONE = 32'h00010000;

    izhikevich_state_update dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dv       (dv),
        .step     (step),
        .out_valid(out_valid),
        .spike    (spike),
        .v_out    (v_out),
        .w_out    (w_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        spk;
        logic [31:0] v;
        logic [31:0] w;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("out_cycle", 32'(cyc), 32'(e.cyc));
                    check("spike", 32'(spike), 32'(e.spk));
                    check("v_out", v_out, e.v);
                    check("w_out", w_out, e.w);
                end
            end else begin
                check("spike_without_valid", 32'(spike), 32'd0);
            end
        end
    end

    task automatic push(input logic s, input logic [31:0] v, input logic [31:0] w);
        exp_t e;
        e.spk = s;
        e.v   = v;
        e.w   = w;
        e.cyc = cyc + 5;  // accept edge is next posedge; result visible 4 edges later
        sbq.push_back(e);
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] s, input logic es,
                        input logic [31:0] ev, input logic [31:0] ew);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dv       = d;
        step     = s;
        push(es, ev, ew);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_v", v_out, 32'hFFBF0000);
        check("rst_w", w_out, 32'hFFF30000);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_spike", 32'(spike), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Sub-threshold step; dw floors to zero.
        send(ONE, ONE, 1'b0, 32'hFFC00000, 32'hFFF30000);
        drain();
        // Half step from v=-64, w=-13: dw = 262 * 0.5 = 131 lsb.
        send(32'h00008000, 32'h00008000, 1'b0, 32'hFFC08000, 32'hFFF30083);
        drain();

        pulse_clear();
        send(32'h00640000, ONE, 1'b1, 32'hFFBF0000, 32'hFFFB0000);
        drain();
        pulse_clear();
        // vn lands exactly on the threshold.
        send(32'h005F0000, ONE, 1'b1, 32'hFFBF0000, 32'hFFFB0000);
        drain();
        pulse_clear();
`ifdef IZH_SAT_EN
        send(32'h80000000, ONE, 1'b0, 32'h80000000, 32'hFFF30000);
`else
        send(32'h80000000, ONE, 1'b1, 32'hFFBF0000, 32'hFFFB0000);
`endif
        drain();
        pulse_clear();

        // Back-to-back: in_valid held high, one accept every 5 cycles.
        @(negedge clk);
        in_valid = 1'b1;
        dv       = ONE;
        step     = ONE;
        for (int i = 0; i < 15; i++) begin
            check("in_ready_stream", 32'(in_ready), (i % 5 == 0) ? 32'd1 : 32'd0);
            if (i == 0) push(1'b0, 32'hFFC00000, 32'hFFF30000);
            if (i == 5) push(1'b0, 32'hFFC10000, 32'hFFF30106);
            if (i == 10) push(1'b0, 32'hFFC20000, 32'hFFF3030D);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // clear in MUL_A aborts a spiking update.
        pulse_clear();
        send(ONE, ONE, 1'b0, 32'hFFC00000, 32'hFFF30000);
        drain();
        @(negedge clk);
        in_valid = 1'b1;
        dv       = 32'h00640000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clear_v", v_out, 32'hFFBF0000);
        check("clear_w", w_out, 32'hFFF30000);
        check("clear_in_ready", 32'(in_ready), 32'd1);
        repeat (8) @(negedge clk);

        // Async reset in MUL_STEP.
        send(ONE, ONE, 1'b0, 32'hFFC00000, 32'hFFF30000);
        drain();
        @(negedge clk);
        in_valid = 1'b1;
        dv       = 32'h00640000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_v", v_out, 32'hFFBF0000);
        check("arst_w", w_out, 32'hFFF30000);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        send(ONE, ONE, 1'b0, 32'hFFC00000, 32'hFFF30000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
